// File: rtl/cape_seq.sv
// Correlated stochastic-number sequencer: latches operands on start, walks a bit-sliced counter, emits one comparator bit per channel.
// Latency: first vector one cycle after start; run lasts 2^(non-bypassed bits) transfers; done pulses one cycle after the last one.
// Backpressure: counter advances only on valid & out_ready; xs/last hold while out_ready is low.
module cape_seq #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4,
    parameter int LEN_W      = WIDTH*NUM_INPUTS+1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        et_en,
    input  logic [WIDTH-1:0]            trunc,
    input  logic [WIDTH*NUM_INPUTS-1:0] bxs,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        valid,
    output logic [NUM_INPUTS-1:0]       xs,
    output logic                        last,
    output logic                        done,
    output logic [LEN_W-1:0]            len
);
    localparam int CW = WIDTH*NUM_INPUTS;
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
    localparam logic [CW-1:0]    ONE_C = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                               state_q, state_d;
    logic [NUM_INPUTS-1:0][WIDTH-1:0]     b_q, b_d, b_new;
    logic [CW-1:0]                        byp_q, byp_d, byp_new;
    logic [CW-1:0]                        cnt_q, cnt_d, cnt_inc;
    logic [LEN_W-1:0]                     tcnt_q, tcnt_d, len_q, len_d;
    logic                                 done_q, done_d;
    logic                                 is_last, xfer;

    // A counter bit is bypassed while every operand bit at or below its weight is zero.
    always_comb begin
        b_new   = '0;
        byp_new = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            logic zero_run;
            zero_run = 1'b1;
            b_new[i] = bxs[i*WIDTH +: WIDTH] & ~trunc;
            for (int j = 0; j < WIDTH; j++) begin
                zero_run = zero_run & ~b_new[i][j];
                byp_new[j*NUM_INPUTS+i] = et_en & zero_run;
            end
        end
    end

    // Forcing bypassed bits to 1 lets the carry ripple straight through them.
    assign cnt_inc = ((cnt_q | byp_q) + ONE_C) & ~byp_q;
    assign is_last = &(cnt_q | byp_q);
    assign busy    = (state_q == RUN);
    assign valid   = busy;
    assign last    = busy & is_last;
    assign done    = done_q;
    assign len     = len_q;
    assign xfer    = busy & out_ready;

    always_comb begin
        xs = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            logic [WIDTH-1:0] w;
            w = '0;
            for (int j = 0; j < WIDTH; j++)
                w[j] = cnt_q[j*NUM_INPUTS+i];
            xs[i] = busy & (w < b_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        byp_d   = byp_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    b_d     = b_new;
                    byp_d   = byp_new;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        len_d   = tcnt_q + ONE_L;
                    end else begin
                        cnt_d  = cnt_inc;
                        tcnt_d = tcnt_q + ONE_L;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            byp_q   <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            byp_q   <= byp_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_cape_seq.sv
// Bench for cape_seq: directed runs plus random traffic, checked every cycle against
// a model that maps the transfer index onto the free counter bits.
module tb_cape_seq;
    localparam int W = 4, NI = 2, N = W*NI, LW = N+1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort, et_en, out_ready;
    logic [W-1:0]  trunc;
    logic [N-1:0]  bxs;
    logic          busy, valid, last, done;
    logic [NI-1:0] xs;
    logic [LW-1:0] len;

    cape_seq #(.WIDTH(W), .NUM_INPUTS(NI), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .et_en(et_en),
        .trunc(trunc), .bxs(bxs), .out_ready(out_ready), .busy(busy), .valid(valid),
        .xs(xs), .last(last), .done(done), .len(len)
    );

    int n_checks = 0, n_pass = 0;

    // model state
    bit           m_busy = 0, m_done = 0;
    int           m_k = 0, m_L = 1, m_len = 0;
    int           m_B [NI];
    logic [N-1:0] m_byp = '0;

    // bench bookkeeping
    logic          s_valid = 1'b0;
    logic [NI-1:0] s_xs = '0;
    bit            seen_done = 0;
    int            tr_cnt, ones0, ones1;
    logic [NI-1:0] seq[$], et_seq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int tz(input logic [W-1:0] b);
        for (int j = 0; j < W; j++) if (b[j]) return j;
        return W;
    endfunction

    // Scatter the bits of k, low to high, into the free counter positions.
    function automatic logic [N-1:0] pdep(input int k, input logic [N-1:0] free);
        logic [N-1:0] r = '0;
        int p = 0;
        for (int pos = 0; pos < N; pos++)
            if (free[pos]) begin r[pos] = 1'((k >> p) & 1); p++; end
        return r;
    endfunction

    task automatic model_start();
        for (int i = 0; i < NI; i++) begin
            logic [W-1:0] b;
            b = bxs[i*W +: W] & ~trunc;
            m_B[i] = int'(b);
            for (int j = 0; j < W; j++) m_byp[j*NI+i] = et_en && (j < tz(b));
        end
        m_L    = 1 << (N - $countones(m_byp));
        m_k    = 0;
        m_busy = 1;
    endtask

    task automatic compare();
        logic [N-1:0]  c;
        logic [NI-1:0] exs;
        c   = pdep(m_k, ~m_byp);
        exs = '0;
        for (int i = 0; i < NI; i++) begin
            int w = 0;
            for (int j = 0; j < W; j++) w += int'(c[j*NI+i]) << j;
            exs[i] = m_busy && (w < m_B[i]);
        end
        chk("busy",  32'(busy),  32'(m_busy));
        chk("valid", 32'(valid), 32'(m_busy));
        chk("xs",    32'(xs),    32'(exs));
        chk("last",  32'(last),  32'(m_busy && (m_k == m_L-1)));
        chk("done",  32'(done),  32'(m_done));
        chk("len",   32'(len),   32'(m_len));
        s_valid = valid;
        s_xs    = xs;
        if (done) seen_done = 1;
    endtask

    task automatic cyc(input bit r, input bit st, input bit ab, input bit en,
                       input logic [W-1:0] tr, input logic [N-1:0] bx, input bit rdy);
        rst_n = r; start = st; abort = ab; et_en = en; trunc = tr; bxs = bx; out_ready = rdy;
        if (r && s_valid && rdy && !ab) begin
            tr_cnt++; ones0 += int'(s_xs[0]); ones1 += int'(s_xs[1]);
            seq.push_back(s_xs);
        end
        @(posedge clk);
        if (!r) begin
            m_busy = 0; m_done = 0; m_len = 0; m_k = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (st) model_start();
            end else if (ab) m_busy = 0;
            else if (rdy) begin
                if (m_k == m_L-1) begin m_busy = 0; m_done = 1; m_len = m_L; end
                else m_k++;
            end
        end
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, '0, '0, 1);
    endtask

    // rmode: 0 ready held high, 1 alternating 0/1, 2 random. Inputs churn during the run.
    task automatic run_case(input bit en, input logic [W-1:0] tr, input logic [N-1:0] bx, input int rmode);
        tr_cnt = 0; ones0 = 0; ones1 = 0; seq.delete();
        cyc(1, 1, 0, en, tr, bx, 1);
        chk("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 2000 && !done; i++) begin
            bit rdy;
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(i % 2) : 1'($urandom_range(0, 1));
            cyc(1, 1'($urandom_range(0, 3) == 0), 0, 1'($urandom_range(0, 1)),
                W'($urandom), N'($urandom), rdy);
        end
        chk("run_done", 32'(done), 32'd1);
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; et_en = 0; trunc = '0; bxs = '0; out_ready = 0;
        cyc(0, 0, 0, 0, '0, '0, 0);
        cyc(0, 1, 0, 1, '0, 8'hFF, 1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xs",   32'(xs),   32'd0);
        chk("rst_len",  32'(len),  32'd0);
        idle(2);

        // full length: B0=8, B1=4
        run_case(0, 4'b0000, 8'h48, 0);
        chk("full_xfers", 32'(tr_cnt), 32'd256);
        chk("full_ones0", 32'(ones0),  32'd128);
        chk("full_ones1", 32'(ones1),  32'd64);
        chk("full_len",   32'(len),    32'd256);

        // back-to-back: start in the done cycle
        run_case(1, 4'b0000, 8'h48, 0);
        chk("et_xfers", 32'(tr_cnt), 32'd8);
        chk("et_ones0", 32'(ones0),  32'd4);
        chk("et_ones1", 32'(ones1),  32'd2);
        chk("et_len",   32'(len),    32'd8);
        et_seq = seq;

        // truncation reduces to the same operands
        run_case(1, 4'b0011, 8'h6B, 0);
        chk("tr_xfers", 32'(seq.size()), 32'(et_seq.size()));
        for (int i = 0; i < seq.size() && i < et_seq.size(); i++)
            chk("tr_seq", 32'(seq[i]), 32'(et_seq[i]));
        chk("tr_len", 32'(len), 32'd8);

        run_case(1, 4'b0000, 8'h00, 0);
        chk("zero_xfers", 32'(tr_cnt), 32'd1);
        chk("zero_ones",  32'(ones0 + ones1), 32'd0);
        chk("zero_len",   32'(len), 32'd1);

        run_case(1, 4'b0000, 8'h48, 1);
        chk("bp_xfers", 32'(seq.size()), 32'd8);
        for (int i = 0; i < seq.size() && i < et_seq.size(); i++)
            chk("bp_seq", 32'(seq[i]), 32'(et_seq[i]));
        chk("bp_len", 32'(len), 32'd8);

        // abort on the third transfer
        cyc(1, 1, 0, 0, '0, 8'h48, 1);
        seen_done = 0;
        cyc(1, 0, 0, 0, '0, '0, 1);
        cyc(1, 1, 0, 0, '0, '0, 1);
        cyc(1, 0, 1, 0, '0, '0, 1);
        chk("abort_busy", 32'(busy), 32'd0);
        idle(3);
        chk("abort_done", 32'(seen_done), 32'd0);
        chk("abort_len",  32'(len), 32'd8);

        // reset mid-run
        cyc(1, 1, 0, 1, '0, 8'h37, 1);
        idle(2);
        cyc(0, 0, 0, 0, '0, '0, 1);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_xs",    32'(xs),    32'd0);
        chk("mrst_last",  32'(last),  32'd0);
        chk("mrst_done",  32'(done),  32'd0);
        chk("mrst_len",   32'(len),   32'd0);
        idle(1);

        for (int i = 0; i < 4000; i++)
            cyc(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0) ? W'($urandom) : '0, N'($urandom),
                1'($urandom_range(0, 2) != 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cape_seq.md
# cape_seq

Handshaked, run-controlled successor to the CAPE correlated stochastic-number generator. On a `start` pulse it latches `NUM_INPUTS` binary operands, runs an interleaved bit-sliced counter, and emits one comparator bit per channel on each accepted cycle. It supports full-length and early-termination (trailing-zero bypass) modes, programmable truncation, output backpressure, abort, and a reported stream length. It sits between operand registers and downstream SC arithmetic and accumulators.

## Interface
- `WIDTH`, 8, operand precision per channel.
- `NUM_INPUTS`, 4, channel count.
- `LEN_W`, `WIDTH*NUM_INPUTS+1`, width of the `len` output.
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begins a run; sampled only in IDLE.
- `abort` in 1: ends a run in RUN without asserting `done`.
- `et_en` in 1: 1 = early-termination mode; latched at start.
- `trunc` in `WIDTH`: mask of operand bits forced to 0; latched at start.
- `bxs` in `WIDTH*NUM_INPUTS`: operand i is `bxs[i*WIDTH +: WIDTH]`; latched at start.
- `out_ready` in 1: downstream accepts the current bit vector.
- `busy` out 1: state is RUN.
- `valid` out 1: `xs` is presented.
- `xs` out `NUM_INPUTS`: stochastic bit per channel.
- `last` out 1: the current `xs` is the final one of the run.
- `done` out 1: one-cycle pulse after the last transfer.
- `len` out `LEN_W`: number of transfers in the completed run.

## Operation
- States: IDLE and RUN.
- IDLE → RUN when `start` is 1. At that edge:
  - latch `B_i = bx_i & ~trunc`;
  - clear counter `C` (`WIDTH*NUM_INPUTS` bits) and the transfer count.
- Bypass mask (registered at start):
  - `et_en=0`: no bits bypassed.
  - `et_en=1`: counter bit `C[j*NUM_INPUTS+i]` is bypassed when `j < tz(B_i)`, where tz is the trailing-zero count. `B_i=0` bypasses all `WIDTH` bits of channel i.
- Channel word: `W_i[j] = C[j*NUM_INPUTS+i]`.
- Output: `xs[i] = (W_i < B_i)`, unsigned compare.
- Advance on transfer (`valid & out_ready`):
  - `C` increments over non-bypassed bits only;
  - bypassed bits are held at 0 and the carry skips them;
  - the transfer count increments.
- Run length `L = 2^(non-bypassed bit count)`. Invariant per run: ones on channel i = `B_i*L/2^WIDTH` exactly.
- `last` = 1 when every non-bypassed bit of `C` is 1. If all bits are bypassed, `last` = 1 on the first and only vector.
- A transfer with `last=1` causes, at the next edge:
  - state → IDLE;
  - `done` = 1 for one cycle;
  - `len` = `L`, held until the next completed run.
- `abort` in RUN causes, at the next edge: state → IDLE, no `done`, `len` unchanged. If `abort` and a last transfer occur in the same cycle, `abort` wins.
- `start` in RUN is ignored. `start` in the cycle `done` is high is accepted.
- Operand, `trunc` and `et_en` changes after start have no effect on the run.

## Timing
- Reset values: state IDLE; `busy`, `valid`, `last`, `done` = 0; `xs` = 0; `len` = 0; `C` = 0.
- Reset asserted mid-run: IDLE at the next edge, no `done`.
- Start sampled at edge k: `busy`/`valid` = 1 from cycle k+1, first `xs` uses `C=0`.
- `valid` = `busy`. `xs` and `last` stay stable while `out_ready=0`.
- With `out_ready` held at 1, the run occupies exactly `L` cycles.
- `done` rises one cycle after the last transfer; `busy` falls the same cycle.
- Minimum restart gap: 0 idle cycles, since start is accepted in the `done` cycle.
- All outputs are registered or decoded from registered state only. No combinational path from `start` or `bxs` to outputs. `out_ready` affects only next-state logic.

## Test plan
Use `WIDTH=4`, `NUM_INPUTS=2` for all scenarios.
- Full mode: `et_en=0`, `B0=8`, `B1=4`, `trunc=0`, ready held at 1 → 256 valid cycles. Ones: ch0=128, ch1=64. `last` on cycle 256, then `done`, `len=256`.
- Early termination: `et_en=1`, `B0=8`, `B1=4` → 8 cycles. Ones: ch0=4, ch1=2. `len=8`.
- Truncation: `trunc=4'b0011`, `bx0=4'b1011`, `bx1=4'b0110`, `et_en=1` → identical `xs` sequence to the early-termination case, `len=8`.
- Zero operands: both 0, `et_en=1` → one cycle with `xs=0` and `last=1`, then `done`, `len=1`.
- Backpressure: repeat the early-termination case with `out_ready` alternating 0/1 → same 8 vectors in order, each held stable while stalled, `len=8`.
- Control: `abort` at the 3rd transfer → `busy` 0 next cycle, no `done`, `len` keeps its prior value. `start` while busy → no effect. `rst_n=0` mid-run → all outputs 0 next cycle. Back-to-back start in the `done` cycle → new run begins next cycle.
